// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  // Buffer entry layout: {pc, inst}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_inst_fifo.sv
// Small instruction buffer: power-of-2 depth, {pc, inst} entries,
// wrap-around pointers, flush has priority over push/pop.
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [63:0]   push_data,
  input  logic          pop,
  output logic [63:0]   head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // Guards keep the pointers consistent even if a caller misbehaves.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != DEPTH_C) || do_pop);

  // Head is zero while empty so stale data never reaches the decoder.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // Storage array; no reset needed, contents are masked by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem reads into a small buffer,
// decoder drains via valid/ready, redirect flushes and restarts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CW = ((BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, new_pc;
  logic [CW-1:0] count, cnt_after_pop, cnt_after;
  logic [63:0]   head;
  logic          push, pop;
  fetch_entry_t  push_ent;
  logic          unused_low_bits;

  assign unused_low_bits = &{1'b0, redirect_pc[1:0]};
  assign new_pc          = align_pc(redirect_pc);

  assign inst_valid = (count != '0);
  assign inst_pc    = head[63:32];
  assign inst       = head[31:0];

  assign pop  = inst_valid && inst_ready;
  assign push = (state == REQ) && imem_ack && !redirect;

  assign push_ent.pc   = fetch_pc;
  assign push_ent.inst = imem_rdata;

  // Occupancy projections used to reserve a slot before issuing a request.
  assign cnt_after_pop = count - {{(CW-1){1'b0}}, pop};
  assign cnt_after     = cnt_after_pop + {{(CW-1){1'b0}}, push};

  // Next-state / next-PC; redirect outranks everything in every state.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = new_pc;
          state_nxt    = REQ;
        end else if (cnt_after_pop < DEPTH_C) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_nxt = new_pc;
          // An unacked request must drain before the new PC can go out.
          state_nxt    = imem_ack ? REQ : DISCARD;
        end else if (imem_ack) begin
          fetch_pc_nxt = fetch_pc + INST_BYTES;
          state_nxt    = (cnt_after < DEPTH_C) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect) fetch_pc_nxt = new_pc;
        if (imem_ack) state_nxt = redirect ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state plus registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      imem_req <= (state_nxt != IDLE);
      // The old address stays on the bus while a discarded read drains.
      if (state_nxt != DISCARD) imem_addr <= fetch_pc_nxt;
    end
  end

  inst_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (reset PC 0 and near-wrap).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack_en = 1'b1;
  logic        ready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        req_a, ack_a, vld_a, req_b, ack_b, vld_b;
  logic [31:0] addr_a, rdata_a, inst_a, pc_a;
  logic [31:0] addr_b, rdata_b, inst_b, pc_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Memory model: zero-wait when enabled, word = address + 0x1000_0000.
  assign ack_a   = req_a & ack_en;
  assign ack_b   = req_b & ack_en;
  assign rdata_a = addr_a + 32'h1000_0000;
  assign rdata_b = addr_b + 32'h1000_0000;

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a),
    .imem_ack(ack_a), .imem_rdata(rdata_a), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(vld_a), .inst_ready(ready),
    .inst(inst_a), .inst_pc(pc_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_b (
    .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata_b), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(vld_b), .inst_ready(ready),
    .inst(inst_b), .inst_pc(pc_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) tick;
    chk("rst_req_a",  32'(req_a), 32'd0);
    chk("rst_addr_a", addr_a, 32'h0);
    chk("rst_vld_a",  32'(vld_a), 32'd0);
    chk("rst_inst_a", inst_a, 32'h0);
    chk("rst_pc_a",   pc_a, 32'h0);
    chk("rst_addr_b", addr_b, 32'hFFFF_FFF8);
    rst = 1'b0;

    // first request, then one instruction per cycle
    tick;
    chk("a_req1",  32'(req_a), 32'd1);
    chk("a_addr1", addr_a, 32'h0);
    chk("a_vld1",  32'(vld_a), 32'd0);
    tick;
    chk("a_pc0",   pc_a, 32'h0);
    chk("a_inst0", inst_a, 32'h1000_0000);
    chk("b_pc0",   pc_b, 32'hFFFF_FFF8);
    chk("b_inst0", inst_b, 32'h0FFF_FFF8);
    tick;
    chk("a_pc4",   pc_a, 32'h4);
    chk("b_pc4",   pc_b, 32'hFFFF_FFFC);
    tick;
    chk("a_pc8",   pc_a, 32'h8);
    chk("a_inst8", inst_a, 32'h1000_0008);
    chk("b_wrap",  pc_b, 32'h0);
    chk("b_winst", inst_b, 32'h1000_0000);

    // decoder stalls: buffer fills, requests stop, nothing lost
    ready = 1'b0;
    repeat (5) tick;
    chk("stall_req", 32'(req_a), 32'd0);
    chk("stall_vld", 32'(vld_a), 32'd1);
    chk("stall_pc",  pc_a, 32'h8);
    ready = 1'b1;
    tick;
    chk("resume_pc",   pc_a, 32'hC);
    chk("resume_req",  32'(req_a), 32'd1);
    chk("resume_addr", addr_a, 32'h10);
    tick;
    chk("resume_pc2",  pc_a, 32'h10);

    // memory stalls 3 cycles: address held, no valid
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wait_addr", addr_a, 32'h14);
      chk("wait_vld",  32'(vld_a), 32'd0);
    end
    ack_en = 1'b1;
    tick;
    chk("wait_pc",   pc_a, 32'h14);
    chk("wait_inst", inst_a, 32'h1000_0014);

    // redirect while a request is outstanding -> discard
    ack_en = 1'b0;
    tick;
    chk("pre_rd_addr", addr_a, 32'h18);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick;
    redirect = 1'b0;
    chk("disc_req",  32'(req_a), 32'd1);
    chk("disc_addr", addr_a, 32'h18);
    chk("disc_vld",  32'(vld_a), 32'd0);
    ack_en = 1'b1;
    tick;
    chk("disc_drop", 32'(vld_a), 32'd0);
    chk("disc_new",  addr_a, 32'h100);
    tick;
    chk("rd_pc",   pc_a, 32'h100);
    chk("rd_inst", inst_a, 32'h1000_0100);

    // redirect coinciding with ack
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick;
    redirect = 1'b0;
    chk("rdack_vld",  32'(vld_a), 32'd0);
    chk("rdack_addr", addr_a, 32'h200);
    chk("rdack_req",  32'(req_a), 32'd1);
    tick;
    chk("rdack_pc",   pc_a, 32'h200);
    chk("rdack_inst", inst_a, 32'h1000_0200);

    // reset pulse while a request is outstanding
    ack_en = 1'b0;
    tick;
    chk("pre_rst_addr", addr_a, 32'h204);
    rst = 1'b1;
    #1;
    chk("arst_req",  32'(req_a), 32'd0);
    chk("arst_addr", addr_a, 32'h0);
    chk("arst_vld",  32'(vld_a), 32'd0);
    chk("arst_addrb", addr_b, 32'hFFFF_FFF8);
    ack_en = 1'b1;
    tick;
    chk("arst_hold_vld", 32'(vld_a), 32'd0);
    chk("arst_hold_pc",  pc_a, 32'h0);
    rst = 1'b0;
    tick;
    chk("rerun_req",  32'(req_a), 32'd1);
    chk("rerun_addr", addr_a, 32'h0);
    tick;
    chk("rerun_pc",  pc_a, 32'h0);
    chk("rerun_vld", 32'(vld_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. Holds the fetch PC, issues single-outstanding word reads to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small FIFO. The decoder consumes the FIFO through a valid/ready handshake. A redirect from execute (branch/jump) flushes the pipeline-front state and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- BUF_DEPTH, 2, instruction buffer entries (power of 2, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  read request to instruction memory
- imem_addr  out  32  word-aligned read address
- imem_ack  in  1  read complete; imem_rdata valid this cycle (may be high in the same cycle imem_req first rises)
- imem_rdata  in  32  instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC (bits [1:0] ignored, forced to 0)
- inst_valid  out  1  buffer head holds a valid instruction
- inst_ready  in  1  decoder accepts head this cycle
- inst  out  32  head instruction word (feeds decoder inst)
- inst_pc  out  32  PC of head instruction

## Operation
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0, FSM IDLE, buffer empty, fetch_pc RESET_PC.
- FSM states: IDLE, REQ, DISCARD; imem_req = (state != IDLE); imem_addr = fetch_pc in IDLE/REQ, held old address in DISCARD.
- IDLE -> REQ when buffer has a free slot (count < BUF_DEPTH after this cycle's pop) and no redirect.
- REQ, ack: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); stay REQ if a slot remains after push/pop, else IDLE.
- REQ, no ack: hold imem_req and imem_addr stable (no address change while a request is outstanding).
- Redirect (highest priority, any state): buffer emptied, fetch_pc <= {redirect_pc[31:2],2'b00}.
  - In REQ without ack: -> DISCARD; keep req/old addr until ack, drop that data, then -> REQ (or IDLE if redirect repeats).
  - In REQ with ack same cycle: data dropped, -> REQ at new PC.
  - In IDLE: -> REQ at new PC. In DISCARD: update fetch_pc, remain DISCARD.
- Pop when inst_valid && inst_ready; push and pop in same cycle leave count unchanged.
- Buffer never overflows: a request is only issued with a reserved slot.
- inst/inst_pc: head entry; 0 when empty.

## Timing
- Zero-wait memory (ack with req): throughput 1 instruction/cycle while decoder ready.
- Reset release at edge 0: imem_req high after edge 1; with immediate ack, inst_valid high after edge 2.
- Redirect sampled at edge t: inst_valid 0 after t; imem_addr = new PC after t (if not DISCARD); first new instruction valid after t+1 with immediate ack.
- inst_valid, inst, inst_pc are register outputs; no combinational path inst_ready -> imem_req.
- rst asserted mid-request: all state returns to reset values immediately; in-flight ack ignored.

## Structure
- fetch_pkg: fetch_state_t enum {IDLE, REQ, DISCARD}, constant INST_BYTES = 4.
- Sub-module inst_fifo: parameterised depth, 64-bit entries {pc, inst}, push/pop/flush, count output, wrap-around pointers.

## Test plan
- Reset, ack every cycle, ready=1 -> inst_pc 0x0,0x4,0x8 on consecutive cycles, inst matches memory model.
- inst_ready=0 for 5 cycles -> buffer fills to 2, imem_req drops to 0, no data lost; ready=1 resumes at next PC in order.
- ack delayed 3 cycles -> imem_addr stable 0x8 throughout, inst_valid low until ack+1.
- redirect to 0x103 while request to 0x8 outstanding -> DISCARD, 0x8 data dropped, next request addr 0x100, first inst_pc 0x100.
- redirect coinciding with ack -> acked data dropped, buffer empty next cycle, next addr = redirect PC.
- RESET_PC 32'hFFFF_FFF8 -> inst_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0; rst pulse mid-wait -> outputs at reset values immediately.
